// File: rtl/kicp_mem_arbiter_pkg.sv
// kicp_mem_arbiter_pkg: op codes, FSM encodings and the
// default SRAM address width shared by the memory arbiter.
package kicp_mem_arbiter_pkg;

   localparam int KICP_SRAM_AWIDTH = 8;

   localparam logic [1:0] MEM_OP_NONE    = 2'b00;
   localparam logic [1:0] MEM_OP_READ    = 2'b01;
   localparam logic [1:0] MEM_OP_WRITE   = 2'b11;
   localparam logic [1:0] MEM_OP_ILLEGAL = 2'b10;

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_ISSUE = 2'b01;
   localparam logic [1:0] ST_WAIT  = 2'b10;
   localparam logic [1:0] ST_DONE  = 2'b11;

   function automatic logic op_is_req(input logic [1:0] op);
      return (op == MEM_OP_READ) || (op == MEM_OP_WRITE);
   endfunction

endpackage

// File: rtl/kicp_mem_arbiter_if.sv
// kicp_mem_arbiter_if: client-side bus of the arbiter.
// Clients use the master modport, the arbiter the slave one.
interface kicp_mem_arbiter_if
   import kicp_mem_arbiter_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int AWIDTH = KICP_SRAM_AWIDTH,
   parameter int DWIDTH = 32
);
   logic [2*NUM_CH-1:0]        ch_op;
   logic [NUM_CH*AWIDTH-1:0]   ch_addr;
   logic [NUM_CH*DWIDTH-1:0]   ch_wdata;
   logic [NUM_CH*DWIDTH/8-1:0] ch_sel;
   logic [NUM_CH-1:0]          ch_done;
   logic [DWIDTH-1:0]          rdata;

   modport master (
      output ch_op, ch_addr, ch_wdata, ch_sel,
      input  ch_done, rdata
   );

   modport slave (
      input  ch_op, ch_addr, ch_wdata, ch_sel,
      output ch_done, rdata
   );
endinterface

// File: rtl/kicp_rr_select.sv
// kicp_rr_select: masked priority encoder. Searches upward
// from last+1 (round-robin) or from 0 (fixed priority).
module kicp_rr_select #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] i_req,
   input  logic [W-1:0] i_last,
   input  logic         i_mode,
   output logic [W-1:0] o_idx,
   output logic         o_valid
);
   logic [W-1:0] w_base;
   logic [N-1:0] w_rot;
   logic [W-1:0] w_off;
   logic [W:0]   w_sum;

   // search origin: slot after the last winner, wrapping at N
   always_comb begin
      w_base = '0;
      if (!i_mode && (i_last != W'(N - 1)))
         w_base = i_last + 1'b1;
   end

   assign w_rot = N'({i_req, i_req} >> w_base);

   // lowest set bit of the rotated request vector
   always_comb begin
      w_off = '0;
      for (int j = N - 1; j >= 0; j--)
         if (w_rot[j]) w_off = W'(j);
   end

   assign w_sum   = {1'b0, w_base} + {1'b0, w_off};
   assign o_idx   = (w_sum >= (W + 1)'(N)) ?
                    W'(w_sum - (W + 1)'(N)) : w_sum[W-1:0];
   assign o_valid = |i_req;
endmodule

// File: rtl/kicp_mem_arbiter.sv
// kicp_mem_arbiter: N-channel arbiter for a single-port SRAM.
// IDLE -> ISSUE -> (WAIT) -> DONE, one transaction at a time.
module kicp_mem_arbiter
   import kicp_mem_arbiter_pkg::*;
#(
   parameter int NUM_CH    = 4,
   parameter int AWIDTH    = KICP_SRAM_AWIDTH,
   parameter int DWIDTH    = 32,
   parameter int PRIO_MODE = 0
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   kicp_mem_arbiter_if.slave         bus,
   output logic                      o_sram_en,
   output logic [DWIDTH/8-1:0]       o_sram_we,
   output logic [AWIDTH-1:0]         o_sram_addr,
   output logic [DWIDTH-1:0]         o_sram_di,
   input  logic [DWIDTH-1:0]         i_sram_do,
   output logic                      o_busy,
   output logic [$clog2(NUM_CH)-1:0] o_grant_id,
   output logic                      o_err
);
   localparam int GW = $clog2(NUM_CH);
   localparam int SW = DWIDTH / 8;

   logic [1:0]        r_state;
   logic [GW-1:0]     r_gid;
   logic [GW-1:0]     r_last;
   logic              r_wr;
   logic              r_en;
   logic [SW-1:0]     r_we;
   logic [AWIDTH-1:0] r_addr;
   logic [DWIDTH-1:0] r_di;
   logic [DWIDTH-1:0] r_rdata;
   logic [NUM_CH-1:0] r_done;
   logic              r_err;

   logic [NUM_CH-1:0] w_req;
   logic              w_ill;
   logic [GW-1:0]     w_win;
   logic              w_vld;
   logic [1:0]        w_op;
   logic [AWIDTH-1:0] w_addr;
   logic [DWIDTH-1:0] w_wdata;
   logic [SW-1:0]     w_sel;
   logic [NUM_CH-1:0] w_gid_oh;

   // requesters are read/write ops; 10 only raises the error
   always_comb begin
      w_req = '0;
      w_ill = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_req[i] = op_is_req(bus.ch_op[2*i +: 2]);
         w_ill    = w_ill |
                    (bus.ch_op[2*i +: 2] == MEM_OP_ILLEGAL);
      end
   end

   kicp_rr_select #(
      .N (NUM_CH),
      .W (GW)
   ) u_sel (
      .i_req   (w_req),
      .i_last  (r_last),
      .i_mode  (PRIO_MODE != 0),
      .o_idx   (w_win),
      .o_valid (w_vld)
   );

   // pick the winning channel's op fields
   always_comb begin
      w_op    = MEM_OP_NONE;
      w_addr  = '0;
      w_wdata = '0;
      w_sel   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (w_win == GW'(i)) begin
            w_op    = bus.ch_op[2*i +: 2];
            w_addr  = bus.ch_addr[AWIDTH*i +: AWIDTH];
            w_wdata = bus.ch_wdata[DWIDTH*i +: DWIDTH];
            w_sel   = bus.ch_sel[SW*i +: SW];
         end
      end
   end

   assign w_gid_oh = NUM_CH'(1) << r_gid;

   // sequencer; SRAM strobes and done are registered here
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
         r_gid   <= '0;
         r_last  <= GW'(NUM_CH - 1);
         r_wr    <= 1'b0;
         r_en    <= 1'b0;
         r_we    <= '0;
         r_addr  <= '0;
         r_di    <= '0;
         r_rdata <= '0;
         r_done  <= '0;
         r_err   <= 1'b0;
      end else begin
         r_en   <= 1'b0;
         r_we   <= '0;
         r_done <= '0;
         unique case (r_state)
            ST_IDLE: begin
               if (w_ill) r_err <= 1'b1;
               if (w_vld) begin
                  r_state <= ST_ISSUE;
                  r_gid   <= w_win;
                  r_wr    <= (w_op == MEM_OP_WRITE);
                  r_addr  <= w_addr;
                  r_di    <= w_wdata;
                  r_en    <= 1'b1;
                  r_we    <= (w_op == MEM_OP_WRITE) ?
                             w_sel : '0;
               end
            end
            ST_ISSUE: begin
               if (r_wr) begin
                  r_state <= ST_DONE;
                  r_done  <= w_gid_oh;
               end else begin
                  r_state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               r_rdata <= i_sram_do;
               r_state <= ST_DONE;
               r_done  <= w_gid_oh;
            end
            default: begin
               r_state <= ST_IDLE;
               if (PRIO_MODE == 0) r_last <= r_gid;
            end
         endcase
      end
   end

   assign o_sram_en   = r_en;
   assign o_sram_we   = r_we;
   assign o_sram_addr = r_addr;
   assign o_sram_di   = r_di;
   assign o_busy      = (r_state != ST_IDLE);
   assign o_grant_id  = r_gid;
   assign o_err       = r_err;
   assign bus.ch_done = r_done;
   assign bus.rdata   = r_rdata;
endmodule

// File: tb/tb_kicp_mem_arbiter.sv
// tb_kicp_mem_arbiter: round-robin and fixed-priority arbiters,
// each attached to a behavioural single-port SRAM.
module tb_kicp_mem_arbiter;
   import kicp_mem_arbiter_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   kicp_mem_arbiter_if #(.NUM_CH(4), .AWIDTH(8), .DWIDTH(32)) bus0();
   kicp_mem_arbiter_if #(.NUM_CH(4), .AWIDTH(8), .DWIDTH(32)) bus1();

   logic       en0, en1, busy0, busy1, err0, err1;
   logic [3:0] we0, we1;
   logic [7:0] ad0, ad1;
   logic [31:0] di0, di1, do0, do1;
   logic [1:0] gid0, gid1;

   kicp_mem_arbiter #(
      .NUM_CH(4), .AWIDTH(8), .DWIDTH(32), .PRIO_MODE(0)
   ) dut0 (
      .i_clk(clk), .i_reset(reset), .bus(bus0),
      .o_sram_en(en0), .o_sram_we(we0), .o_sram_addr(ad0),
      .o_sram_di(di0), .i_sram_do(do0), .o_busy(busy0),
      .o_grant_id(gid0), .o_err(err0)
   );

   kicp_mem_arbiter #(
      .NUM_CH(4), .AWIDTH(8), .DWIDTH(32), .PRIO_MODE(1)
   ) dut1 (
      .i_clk(clk), .i_reset(reset), .bus(bus1),
      .o_sram_en(en1), .o_sram_we(we1), .o_sram_addr(ad1),
      .o_sram_di(di1), .i_sram_do(do1), .o_busy(busy1),
      .o_grant_id(gid1), .o_err(err1)
   );

   logic [31:0] mem0 [256];
   logic [31:0] mem1 [256];

   // SRAM models; the round-robin one is preloaded under reset
   always @(posedge clk) begin
      if (reset) begin
         mem0[8'h10] <= 32'hDEADBEEF;
         mem0[8'h05] <= 32'hAAAAAAAA;
         for (int c = 0; c < 4; c++)
            mem0[8'h30 + 8'(c)] <= 32'h1000 + 32'(c);
      end else if (en0) begin
         for (int b = 0; b < 4; b++)
            if (we0[b]) mem0[ad0][8*b +: 8] <= di0[8*b +: 8];
         do0 <= mem0[ad0];
      end
   end

   always @(posedge clk) begin
      if (en1) begin
         for (int b = 0; b < 4; b++)
            if (we1[b]) mem1[ad1][8*b +: 8] <= di1[8*b +: 8];
         do1 <= mem1[ad1];
      end
   end

   typedef struct {
      int          ch;
      logic [1:0]  op;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  sel;
      logic [31:0] xd;
      int          lat;
   } vec_t;

   typedef struct {
      int          ch;
      logic [31:0] xd;
      int          lat;
   } sb_t;

   vec_t tv [11];
   sb_t  sbq [$];
   sb_t  e;
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual %0h required %0h", nm, act, req);
      end
   endtask

   task automatic wait_done(input int d, input int bound,
                            output logic [3:0] dv, output int cyc,
                            output int ens, output logic [7:0] ea,
                            output logic [3:0] ew);
      dv = '0; cyc = 0; ens = 0; ea = '0; ew = '0;
      while (dv == '0 && cyc < bound) begin
         @(posedge clk); #1;
         cyc++;
         if (d == 0) begin
            dv = bus0.ch_done;
            if (en0) begin ens++; ea = ad0; ew = we0; end
         end else begin
            dv = bus1.ch_done;
            if (en1) begin ens++; ea = ad1; ew = we1; end
         end
      end
      if (dv == '0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL timeout dut%0d: no done in %0d cycles",
                  d, bound);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [3:0] dv;
      logic [7:0] ea;
      logic [3:0] ew;
      int cyc, ens, dn, bz;

      tv[0]  = '{1, MEM_OP_READ,  8'h10, 32'h0, 4'h0,
                 32'hDEADBEEF, 3};
      tv[1]  = '{0, MEM_OP_WRITE, 8'h05, 32'h11223344, 4'b0101,
                 32'hDEADBEEF, 2};
      tv[2]  = '{2, MEM_OP_READ,  8'h05, 32'h0, 4'h0,
                 32'hAA22AA44, 3};
      tv[3]  = '{3, MEM_OP_WRITE, 8'h20, 32'hCAFEF00D, 4'b1111,
                 32'hAA22AA44, 2};
      tv[4]  = '{3, MEM_OP_READ,  8'h20, 32'h0, 4'h0,
                 32'hCAFEF00D, 3};
      tv[5]  = '{0, MEM_OP_WRITE, 8'h20, 32'h000000FF, 4'b1000,
                 32'hCAFEF00D, 2};
      tv[6]  = '{1, MEM_OP_READ,  8'h20, 32'h0, 4'h0,
                 32'h00FEF00D, 3};
      tv[7]  = '{2, MEM_OP_WRITE, 8'hFF, 32'h5A5A5A5A, 4'b1111,
                 32'h00FEF00D, 2};
      tv[8]  = '{0, MEM_OP_READ,  8'hFF, 32'h0, 4'h0,
                 32'h5A5A5A5A, 3};
      tv[9]  = '{1, MEM_OP_WRITE, 8'h05, 32'hFFFFFFFF, 4'b0000,
                 32'h5A5A5A5A, 2};
      tv[10] = '{3, MEM_OP_READ,  8'h05, 32'h0, 4'h0,
                 32'hAA22AA44, 3};

      bus0.ch_op = '0; bus0.ch_addr = '0;
      bus0.ch_wdata = '0; bus0.ch_sel = '0;
      bus1.ch_op = '0; bus1.ch_addr = '0;
      bus1.ch_wdata = '0; bus1.ch_sel = '0;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst sram_en", 32'(en0), 0);
      chk("rst sram_we", 32'(we0), 0);
      chk("rst sram_addr", 32'(ad0), 0);
      chk("rst sram_di", di0, 0);
      chk("rst busy", 32'(busy0), 0);
      chk("rst grant_id", 32'(gid0), 0);
      chk("rst err", 32'(err0), 0);
      chk("rst ch_done", 32'(bus0.ch_done), 0);
      chk("rst rdata", bus0.rdata, 0);
      reset = 1'b0;

      // round-robin: all four channels read continuously
      bus0.ch_op = 8'b01010101;
      for (int c = 0; c < 4; c++)
         bus0.ch_addr[8*c +: 8] = 8'h30 + 8'(c);
      for (int k = 0; k < 8; k++)
         sbq.push_back('{k % 4, 32'h1000 + 32'(k % 4),
                         (k == 0) ? 3 : 4});
      for (int k = 0; k < 8; k++) begin
         wait_done(0, 12, dv, cyc, ens, ea, ew);
         e = sbq.pop_front();
         chk($sformatf("rr%0d order", k), 32'(dv), 32'(1) << e.ch);
         chk($sformatf("rr%0d spacing", k), cyc, e.lat);
         chk($sformatf("rr%0d rdata", k), bus0.rdata, e.xd);
         chk($sformatf("rr%0d grant_id", k), 32'(gid0), e.ch);
      end
      bus0.ch_op = '0;
      @(posedge clk); #1;
      chk("rr idle busy", 32'(busy0), 0);

      // single-channel vector table
      for (int i = 0; i < 11; i++) begin
         bus0.ch_op[2*tv[i].ch +: 2]     = tv[i].op;
         bus0.ch_addr[8*tv[i].ch +: 8]   = tv[i].addr;
         bus0.ch_wdata[32*tv[i].ch +: 32] = tv[i].wdata;
         bus0.ch_sel[4*tv[i].ch +: 4]    = tv[i].sel;
         sbq.push_back('{tv[i].ch, tv[i].xd, tv[i].lat});
         wait_done(0, 10, dv, cyc, ens, ea, ew);
         bus0.ch_op[2*tv[i].ch +: 2] = MEM_OP_NONE;
         e = sbq.pop_front();
         chk($sformatf("vec%0d done", i), 32'(dv), 32'(1) << e.ch);
         chk($sformatf("vec%0d latency", i), cyc, e.lat);
         chk($sformatf("vec%0d rdata", i), bus0.rdata, e.xd);
         chk($sformatf("vec%0d en_count", i), ens, 1);
         chk($sformatf("vec%0d sram_addr", i), 32'(ea),
             32'(tv[i].addr));
         chk($sformatf("vec%0d sram_we", i), 32'(ew),
             (tv[i].op == MEM_OP_WRITE) ? 32'(tv[i].sel) : 0);
         @(posedge clk); #1;
      end

      // fixed priority: ch0 starves ch2 until it lets go
      bus1.ch_op = 8'b00110011;
      bus1.ch_addr = 32'h00420040;
      bus1.ch_wdata = {32'h0, 32'h22222222, 32'h0, 32'h11111111};
      bus1.ch_sel = 16'h0F0F;
      for (int k = 0; k < 5; k++) begin
         wait_done(1, 10, dv, cyc, ens, ea, ew);
         chk($sformatf("fp%0d winner", k), 32'(dv), 32'h1);
         chk($sformatf("fp%0d spacing", k), cyc, (k == 0) ? 2 : 3);
      end
      bus1.ch_op[1:0] = MEM_OP_NONE;
      wait_done(1, 10, dv, cyc, ens, ea, ew);
      chk("fp ch2 after drop", 32'(dv), 32'h4);
      chk("fp ch2 latency", cyc, 3);
      chk("fp ch2 grant_id", 32'(gid1), 2);
      bus1.ch_op = '0;
      @(posedge clk); #1;
      chk("fp mem ch2", mem1[8'h42], 32'h22222222);

      // illegal op alone: no service, sticky error
      chk("ill err before", 32'(err0), 0);
      bus0.ch_op[7:6] = MEM_OP_ILLEGAL;
      ens = 0; dn = 0; bz = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (en0) ens++;
         if (bus0.ch_done != '0) dn++;
         if (busy0) bz++;
      end
      chk("ill err set", 32'(err0), 1);
      chk("ill no sram_en", ens, 0);
      chk("ill no done", dn, 0);
      chk("ill no busy", bz, 0);

      // illegal op beside a legal one: only the legal is served
      bus0.ch_op[1:0] = MEM_OP_ILLEGAL;
      bus0.ch_op[3:2] = MEM_OP_READ;
      bus0.ch_addr[15:8] = 8'h10;
      bus0.ch_op[7:6] = MEM_OP_NONE;
      wait_done(0, 10, dv, cyc, ens, ea, ew);
      bus0.ch_op = '0;
      chk("ill+rd done", 32'(dv), 32'h2);
      chk("ill+rd rdata", bus0.rdata, 32'hDEADBEEF);
      repeat (5) @(posedge clk);
      #1;
      chk("ill err sticky", 32'(err0), 1);
      chk("ill other dut err", 32'(err1), 0);

      // reset while a read sits in WAIT
      bus0.ch_op[3:2] = MEM_OP_READ;
      bus0.ch_addr[15:8] = 8'h30;
      @(posedge clk); #1;
      chk("rw issue en", 32'(en0), 1);
      @(posedge clk); #1;
      chk("rw wait busy", 32'(busy0), 1);
      reset = 1'b1;
      bus0.ch_op = '0;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rw busy", 32'(busy0), 0);
      chk("rw sram_en", 32'(en0), 0);
      chk("rw rdata", bus0.rdata, 0);
      chk("rw err", 32'(err0), 0);
      chk("rw grant_id", 32'(gid0), 0);
      chk("rw ch_done", 32'(bus0.ch_done), 0);
      dn = 0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         if (bus0.ch_done != '0) dn++;
      end
      chk("rw no stale done", dn, 0);

      // after reset, ch0 outranks ch1
      bus0.ch_op = 8'b00000101;
      bus0.ch_addr = 32'h00003130;
      sbq.push_back('{0, 32'h1000, 3});
      sbq.push_back('{1, 32'h1001, 3});
      for (int k = 0; k < 2; k++) begin
         wait_done(0, 12, dv, cyc, ens, ea, ew);
         e = sbq.pop_front();
         bus0.ch_op[2*e.ch +: 2] = MEM_OP_NONE;
         chk($sformatf("post%0d order", k), 32'(dv), 32'(1) << e.ch);
         chk($sformatf("post%0d rdata", k), bus0.rdata, e.xd);
      end
      @(posedge clk); #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/kicp_mem_arbiter.md
Name: kicp_mem_arbiter

Overview:
- Parametrised N-channel arbiter for the accelerator's single-port SRAM (RAM256 class). Replaces the fixed three-client memory controller: Wishbone DMA, matrix multiplication, matrix convolution and future cores.
- Each client issues a read or write op and holds it until a one-cycle done pulse.
- Arbitration is round-robin or fixed priority. Byte enables are supported.
- A sticky error flag records illegal op codes.

Parameters:
- NUM_CH, 4, number of client channels (2..8).
- AWIDTH, 8, SRAM word-address width (`KICP_SRAM_AWIDTH).
- DWIDTH, 32, data width; must be a multiple of 8.
- PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ch_op  in  2*NUM_CH  per-channel op: 00 none, 01 read, 11 write, 10 illegal
- ch_addr  in  NUM_CH*AWIDTH  per-channel word address
- ch_wdata  in  NUM_CH*DWIDTH  per-channel write data
- ch_sel  in  NUM_CH*DWIDTH/8  per-channel byte enables (writes only)
- ch_done  out  NUM_CH  one-cycle completion pulse to the granted channel
- rdata  out  DWIDTH  last read result, shared by all channels
- sram_en  out  1  SRAM enable
- sram_we  out  DWIDTH/8  SRAM byte write enables
- sram_addr  out  AWIDTH  SRAM address
- sram_di  out  DWIDTH  SRAM write data
- sram_do  in  DWIDTH  SRAM read data, valid one cycle after sram_en
- busy  out  1  high in any state other than IDLE
- grant_id  out  $clog2(NUM_CH)  currently or last served channel
- err  out  1  sticky; set when a granted-eligible channel presents op 10

Behaviour:
- Single clock, clk. reset is synchronous and active-high; it takes effect at the next rising edge.
- Reset values:
  - state = IDLE
  - all outputs 0 (ch_done, rdata, sram_*, busy, grant_id, err)
  - round-robin pointer last = NUM_CH-1, so channel 0 has top priority first
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Requesting set = channels with op 01 or 11.
  - If the set is non-empty, the edge selects a winner g:
    - PRIO_MODE=0: first requester searching last+1, last+2, … (mod NUM_CH).
    - PRIO_MODE=1: lowest index.
  - The same edge latches op, addr, wdata and sel of g, sets grant_id = g, and moves to ISSUE.
  - If the set is empty, stay in IDLE.
- ISSUE:
  - sram_en=1, sram_addr = latched addr.
  - Write: sram_we = latched sel, sram_di = latched wdata, next state DONE.
  - Read: sram_we = 0, next state WAIT.
- WAIT: sram_en=0; rdata <= sram_do at the edge; next state DONE.
- DONE: ch_done[g]=1 for exactly this cycle; last <= g (round-robin only); next state IDLE.
- rdata holds until the next read completes; writes never change it.
- Latency, request-visible cycle to done cycle: read 3, write 2. Minimum spacing per transaction: read 4 cycles, write 3 (IDLE turnaround).
- Client rule: hold op/addr/wdata/sel until the done pulse is sampled; drop or change op at that same edge. The arbiter uses only latched values, so mid-service input changes are ignored.
- A channel still requesting in the IDLE after its own DONE is eligible again. In round-robin mode it ranks last.
- Simultaneous requests: exactly one grant; the rest wait with no loss of request.
- Op 10: never granted; treated as none for arbitration; sets err (cleared only by reset).
- Reset mid-operation: the transaction is abandoned, no done pulse is issued, and the SRAM is not written after the reset edge.
- sram_we/sram_en are 0 in every state except ISSUE, with no glitch paths; outputs are driven from registered state plus the latched fields.

Decomposition:
- Shared defines header (kicp_mem_defs.vh): MEM_OP_NONE=2'b00, MEM_OP_READ=2'b01, MEM_OP_WRITE=2'b11, MEM_OP_ILLEGAL=2'b10, state encodings, `KICP_SRAM_AWIDTH.
- Sub-module kicp_rr_select: combinational masked priority encoder (request vector, last pointer, mode → winner index + valid). It is reusable by future interrupt and DMA arbiters.

Test Plan:
- Single read: preload addr 0x10 = 0xDEADBEEF; ch1 op=01 addr=0x10 → sram_en high one cycle, ch_done[1] 3 cycles after request, rdata = 0xDEADBEEF.
- Byte write: ch0 write addr 0x05 data 0x11223344 sel=0101, prior contents 0xAAAAAAAA → later read returns 0xAA22AA44; ch_done[0] 2 cycles after request.
- Round-robin fairness: NUM_CH=4, all channels requesting continuously → grant order 0,1,2,3,0,…; no channel served twice before the others once.
- Fixed priority: PRIO_MODE=1, ch0 and ch2 request continuously → ch2 is never granted while ch0 holds its request (starvation by design); ch2 is granted the IDLE after ch0 drops.
- Illegal op: ch3 op=10 alone → no sram_en, no ch_done, err=1 and it stays 1 until reset.
- Reset in WAIT: assert reset during a ch1 read → next cycle state IDLE, all outputs 0, no ch_done[1]; a new request after reset is granted to ch0 first when ch0 and ch1 both request.
